// File: rtl/lop_norm_pipe.sv
// Three-stage elastic add/subtract, leading-one detect and normalise pipeline.
// S1 forms the signed magnitude sum, S2 finds the normalisation shift, S3 drives the outputs.
module lop_norm_pipe #(
  parameter  int MANT_W = 24,
  parameter  int EXP_W  = 8,
  localparam int SH_W   = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [MANT_W-1:0] op1,
  input  logic [MANT_W-1:0] op2,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [SH_W-1:0]   shift,
  output logic              shift_dir,
  output logic              zero,
  output logic              ovf,
  output logic              uf
);

  localparam int CW = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;

  logic              s1_v_q, s2_v_q, out_valid_q;
  logic              s1_hold, s2_hold, s3_hold;

  logic [MANT_W:0]   sum_d;
  logic              s1_sign_d;
  logic [MANT_W:0]   s1_sum_q;
  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;

  logic [SH_W-1:0]   s2_sh_d;
  logic              s2_dir_d, s2_zero_d;
  logic [MANT_W:0]   s2_sum_q;
  logic              s2_sign_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [SH_W-1:0]   s2_sh_q;
  logic              s2_dir_q, s2_zero_q;

  logic [EXP_W:0]    exp_inc;
  logic [CW-1:0]     exp_ext, sh_ext;
  logic              sign_d, dir_d, zero_d, ovf_d, uf_d;
  logic [MANT_W-1:0] mant_d;
  logic [EXP_W-1:0]  exp_d;
  logic [SH_W-1:0]   sh_d;

  logic              sign_q, dir_q, zero_q, ovf_q, uf_q;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic [SH_W-1:0]   sh_q;

  // Stall chain: each stage holds only when it is full and everything downstream holds.
  assign s3_hold  = out_valid_q & ~out_ready;
  assign s2_hold  = s2_v_q & s3_hold;
  assign s1_hold  = s1_v_q & s2_hold;
  assign in_ready = ~rst & ~s1_hold;

  // S1: signed magnitude sum
  always_comb begin
    sum_d     = '0;
    s1_sign_d = sign1;
    if (sign1 == sign2) begin
      sum_d = {1'b0, op1} + {1'b0, op2};
    end else if (op1 >= op2) begin
      sum_d = {1'b0, op1 - op2};
    end else begin
      sum_d     = {1'b0, op2 - op1};
      s1_sign_d = sign2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
    end else if (!s1_hold) begin
      s1_v_q    <= in_valid;
      s1_sum_q  <= sum_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= exp_in;
    end
  end

  // S2: leading-one detect; the ascending scan leaves the most significant one's shift
  always_comb begin
    s2_sh_d   = '0;
    s2_dir_d  = 1'b0;
    s2_zero_d = (s1_sum_q == '0);
    if (s1_sum_q[MANT_W]) begin
      s2_dir_d = 1'b1;
      s2_sh_d  = SH_W'(1);
    end else begin
      for (int unsigned i = 0; i < MANT_W; i++) begin
        if (s1_sum_q[i]) s2_sh_d = SH_W'(MANT_W - 1 - i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
    end else if (!s2_hold) begin
      s2_v_q    <= s1_v_q;
      s2_sum_q  <= s1_sum_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_sh_q   <= s2_sh_d;
      s2_dir_q  <= s2_dir_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  // S3: result classification, priority zero > carry/ovf > left/uf
  always_comb begin
    exp_inc = {1'b0, s2_exp_q} + (EXP_W + 1)'(1);
    exp_ext = CW'(s2_exp_q);
    sh_ext  = CW'(s2_sh_q);
    sign_d  = s2_sign_q;
    mant_d  = '0;
    exp_d   = '0;
    sh_d    = s2_sh_q;
    dir_d   = s2_dir_q;
    zero_d  = 1'b0;
    ovf_d   = 1'b0;
    uf_d    = 1'b0;
    if (s2_zero_q) begin
      sign_d = 1'b0;
      sh_d   = '0;
      dir_d  = 1'b0;
      zero_d = 1'b1;
    end else if (s2_dir_q) begin
      if (exp_inc == {1'b0, {EXP_W{1'b1}}}) begin
        ovf_d = 1'b1;
        exp_d = '1;
      end else begin
        mant_d = s2_sum_q[MANT_W:1];
        exp_d  = exp_inc[EXP_W-1:0];
      end
    end else if (exp_ext <= sh_ext) begin
      uf_d = 1'b1;
    end else begin
      mant_d = s2_sum_q[MANT_W-1:0] << s2_sh_q;
      exp_d  = EXP_W'(exp_ext - sh_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      sh_q        <= '0;
      dir_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
    end else if (!s3_hold) begin
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        sign_q <= sign_d;
        mant_q <= mant_d;
        exp_q  <= exp_d;
        sh_q   <= sh_d;
        dir_q  <= dir_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
        uf_q   <= uf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sign_out  = sign_q;
  assign mant_out  = mant_q;
  assign exp_out   = exp_q;
  assign shift     = sh_q;
  assign shift_dir = dir_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign uf        = uf_q;

endmodule

// File: tb/tb_lop_norm_pipe.sv
// Self-checking bench for lop_norm_pipe (MANT_W=8, EXP_W=8): directed cases, stall/capacity,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_lop_norm_pipe;
  localparam int MW = 8;
  localparam int EW = 8;
  localparam int SW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic          sign1, sign2;
  logic [MW-1:0] op1, op2;
  logic [EW-1:0] exp_in;
  logic          out_valid, out_ready;
  logic          sign_out;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;
  logic [SW-1:0] shift;
  logic          shift_dir, zero, ovf, uf;

  lop_norm_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign1(sign1), .sign2(sign2), .op1(op1), .op2(op2), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .mant_out(mant_out), .exp_out(exp_out), .shift(shift), .shift_dir(shift_dir),
    .zero(zero), .ovf(ovf), .uf(uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sign, mant, exp, shift, dir, zero, ovf, uf;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   emitted = 0;
  bit   accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input bit s1, input bit s2, input int o1, input int o2, input int e);
    res_t r;
    int   sum, m, n;
    bit   sg;
    r = '{default: 0};
    if (s1 == s2) begin
      sum = o1 + o2; sg = s1;
    end else if (o1 >= o2) begin
      sum = o1 - o2; sg = s1;
    end else begin
      sum = o2 - o1; sg = s2;
    end
    if (sum == 0) begin
      r.zero = 1;
    end else if (sum >= (1 << MW)) begin
      r.dir = 1; r.shift = 1; r.sign = sg;
      if (e + 1 == (1 << EW) - 1) begin
        r.ovf = 1; r.exp = (1 << EW) - 1;
      end else begin
        r.mant = sum / 2; r.exp = (e + 1) % (1 << EW);
      end
    end else begin
      m = sum; n = 0;
      while (m < (1 << (MW - 1))) begin
        m = m * 2; n++;
      end
      r.shift = n; r.sign = sg;
      if (e <= n) r.uf = 1;
      else begin
        r.mant = m; r.exp = e - n;
      end
    end
    return r;
  endfunction

  // One clock: sample just after the falling-edge drive, score, then advance to the next falling edge.
  task automatic tick();
    #1;
    accepted = 0;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) check("no_stale_valid", out_valid, 0);
        else begin
          check("sign",  sign_out,  sb[0].sign);
          check("mant",  mant_out,  sb[0].mant);
          check("exp",   exp_out,   sb[0].exp);
          check("shift", shift,     sb[0].shift);
          check("dir",   shift_dir, sb[0].dir);
          check("zero",  zero,      sb[0].zero);
          check("ovf",   ovf,       sb[0].ovf);
          check("uf",    uf,        sb[0].uf);
          if (out_ready) begin
            void'(sb.pop_front());
            emitted++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(sign1, sign2, op1, op2, exp_in));
        accepted = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit s1, input bit s2, input int o1, input int o2, input int e);
    sign1 = s1; sign2 = s2; op1 = MW'(o1); op2 = MW'(o2); exp_in = EW'(e);
  endtask

  task automatic drive_rand();
    int o1, o2, e;
    o1 = $urandom_range(0, 255);
    o2 = $urandom_range(0, 255);
    e  = $urandom_range(1, 254);
    case ($urandom_range(0, 7))
      0: o2 = o1;
      1: begin o1 = $urandom_range(0, 7); o2 = $urandom_range(0, 7); e = $urandom_range(1, 8); end
      2: e = $urandom_range(250, 254);
      default: ;
    endcase
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o1, o2, e);
  endtask

  task automatic run_one(input bit s1, input bit s2, input int o1, input int o2, input int e,
                         input int em, input int ee, input logic [2:0] ef);
    int n;
    drive(s1, s2, o1, o2, e);
    in_valid = 1;
    tick();
    check("dir_accept", accepted, 1);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    #1;
    check("dir_latency", n, 3);
    check("dir_mant", mant_out, em);
    check("dir_exp", exp_out, ee);
    check("dir_flags", {zero, ovf, uf}, ef);
    tick();
  endtask

  initial begin
    int k, n;
    rst = 1; in_valid = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sign", sign_out, 0);
    check("rst_mant", mant_out, 0);
    check("rst_exp", exp_out, 0);
    check("rst_shift", shift, 0);
    check("rst_dir", shift_dir, 0);
    check("rst_flags", {zero, ovf, uf}, 0);
    check("rst_in_ready_after", in_ready, 1);

    run_one(0, 0, 'h45, 'h01, 'h10, 'h8C, 'h0F, 3'b000);
    run_one(1, 1, 'hC0, 'h80, 'h10, 'hA0, 'h11, 3'b000);
    run_one(1, 1, 'hC0, 'h80, 'hFE, 'h00, 'hFF, 3'b010);
    run_one(0, 1, 'h01, 'h45, 'h10, 'h88, 'h0F, 3'b000);
    run_one(0, 1, 'h45, 'h45, 'h10, 'h00, 'h00, 3'b100);
    run_one(0, 1, 'h03, 'h01, 'h02, 'h00, 'h00, 3'b001);

    // Capacity with a stalled sink, then drain at full rate.
    out_ready = 0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 5) begin
        drive(k[0], 0, 'h21 + k * 3, 'h05 + k, 'h40 + k);
        in_valid = 1;
      end
      tick();
      if (accepted) k++;
    end
    #1;
    check("cap_accepts", k, 3);
    check("cap_in_ready", in_ready, 0);
    out_ready = 1;
    emitted = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 5) begin
        drive(k[0], 0, 'h21 + k * 3, 'h05 + k, 'h40 + k);
        in_valid = 1;
      end else in_valid = 0;
      tick();
      if (accepted) k++;
    end
    in_valid = 0;
    check("drain_emitted", emitted, 5);
    check("drain_accepts", k, 5);
    check("drain_empty", sb.size(), 0);

    // Reset with three operations in flight.
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      drive_rand();
      in_valid = 1;
      tick();
    end
    check("rst_fill", sb.size(), 3);
    rst = 1;
    drive_rand();
    tick();
    rst = 0;
    in_valid = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_mant", mant_out, 0);
    check("mid_rst_exp", exp_out, 0);
    check("mid_rst_misc", {sign_out, shift_dir, shift}, 0);
    check("mid_rst_flags", {zero, ovf, uf}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (6) tick();

    // Randomized traffic with random backpressure.
    repeat (400) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) begin
        drive_rand();
        in_valid = 1;
      end else in_valid = 0;
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check("final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lop_norm_pipe.md
# lop_norm_pipe

Parametrised, three-stage pipelined add/subtract-and-normalise unit for the floating-point co-processor datapath. It takes two exponent-aligned mantissa magnitudes with their signs and a common exponent. It forms the signed sum, locates the leading one, normalises the mantissa so the hidden bit sits at bit MANT_W-1, and adjusts the exponent, flagging zero, overflow and underflow. It sits between the alignment shifter and the rounding stage, and supersedes the combinational 8-bit leading-one/shift-count logic with a width-generic, flow-controlled block.

## Interface
- MANT_W, 24, mantissa width including hidden bit (min 4)
- EXP_W, 8, biased exponent width (min 3)
- SH_W, $clog2(MANT_W+1), shift-count width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts input this cycle
- sign1, sign2  in  1 each  operand signs (1 = negative)
- op1, op2  in  MANT_W each  aligned mantissa magnitudes
- exp_in  in  EXP_W  common (larger) exponent
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sign_out  out  1  result sign
- mant_out  out  MANT_W  normalised mantissa
- exp_out  out  EXP_W  adjusted exponent
- shift  out  SH_W  normalisation shift amount applied
- shift_dir  out  1  0 = left shift (or none), 1 = right by one (carry)
- zero, ovf, uf  out  1 each  result-class flags

## Operation
- S1 (arith):
  - Same signs: sum = op1+op2, MANT_W+1 bits; sign = sign1.
  - Different signs: if op1>=op2 then sum = op1-op2, sign = sign1; else sum = op2-op1, sign = sign2.
- S2 (detect): lead = index of the most significant 1 in sum.
  - sum[MANT_W]=1: carry; dir = 1, shift = 1.
  - Otherwise: dir = 0, shift = MANT_W-1-lead.
  - sum==0: zero class.
- S3 (normalise), result classes in priority order:
  - Zero: mant 0, exp 0, sign 0, shift 0, dir 0, zero=1.
  - Carry: mant = sum[MANT_W:1] (LSB truncated, no sticky); exp = exp_in+1.
  - Left: mant = sum[MANT_W-1:0] << shift; exp = exp_in - shift.
  - ovf: exp_in+1 == 2^EXP_W-1 on carry. exp = all-ones, mant = 0, sign kept.
  - uf: exp_in <= shift on a left shift. exp 0, mant 0, sign kept, shift reports the computed value.
  - At most one flag is asserted.
- Flow control is an elastic pipeline with one register per stage (S1, S2, S3; S3 drives outputs).
  - A stage holds while it is valid and the next stage holds; S3 holds while out_valid & !out_ready.
  - in_ready = !rst & !(S1 valid & S1 holding).
  - Input is accepted on a rising edge with in_valid & in_ready.
  - Results leave in order, with no loss or duplication.
- Reset:
  - Clears all stage valid bits and all output registers to 0.
  - In-flight operations are discarded.
  - in_ready is 0 while rst is high.

## Timing
- Operand accepted at edge t → S1 at t, S2 at t+1, outputs at t+2. out_valid is high from after edge t+2.
- Throughput one result per clock when out_ready is held high.
- Output data and flags are registered and stable while out_valid & !out_ready.
- Capacity is 3 operations. With out_ready low, in_ready falls after the third accept and stays 0 until S3 drains.
- in_ready may depend combinationally on out_ready (stall chain). No other combinational input→output path.
- Reset values: out_valid 0, sign_out 0, mant_out 0, exp_out 0, shift 0, shift_dir 0, zero/ovf/uf 0, in_ready 0 during rst, 1 the cycle after.
- Simultaneous accept and emit in a full pipeline: all stages advance; no bubble is inserted.

## Test plan
All cases use MANT_W=8, EXP_W=8, out_ready=1 unless stated.
- op1=0x45, op2=0x01, signs 0/0, exp_in=0x10 → mant 0x8C, exp 0x0F, sign 0, shift 1, dir 0, flags 0, out_valid 3 edges after accept.
- op1=0xC0, op2=0x80, signs 1/1, exp_in=0x10 → carry: mant 0xA0, exp 0x11, sign 1, shift 1, dir 1. Repeat with exp_in=0xFE → ovf=1, exp 0xFF, mant 0.
- op1=0x01, op2=0x45, signs 0/1, exp_in=0x10 → mant 0x88, exp 0x0F, sign 1, shift 1. Repeat with op1=op2=0x45 → zero=1, mant 0, exp 0, sign 0.
- op1=0x03, op2=0x01, signs 0/1, exp_in=0x02 → sum 0x02, shift 6, uf=1, exp 0, mant 0.
- Stream 5 distinct operands, out_ready low: in_ready drops after 3 accepts and the first result is held stable. Raise out_ready → all 5 results emerge in order, one per clock, with no duplicates.
- Assert rst for one cycle with 3 operations in flight → the next cycle shows out_valid 0, all outputs 0, in_ready 1, and no stale result ever appears.
